coin_intake: RTL and testbench



---
 rtl/vm_pkg.sv | 32 +++
 rtl/coin_debounce.sv | 79 +++++++
 rtl/coin_intake.sv | 101 ++++++++++
 tb/tb_coin_intake.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/vm_pkg.sv
// Shared definitions for the vending-machine coin path: coin codes and the
// per-channel debounce state encoding.
package vm_pkg;

  typedef logic [1:0] coin_t;

  localparam coin_t COIN_NONE = 2'd0;
  localparam coin_t COIN_N    = 2'd1;
  localparam coin_t COIN_D    = 2'd2;
  localparam coin_t COIN_Q    = 2'd3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL_HI = 2'd1,
    HELD    = 2'd2,
    QUAL_LO = 2'd3
  } chan_state_e;

  // Coin code to the {q, d, n} one-hot presented to the drink FSM.
  function automatic logic [2:0] coin_onehot(input coin_t c);
    logic [2:0] oh;
    oh = 3'b000;
    case (c)
      COIN_N:  oh = 3'b001;
      COIN_D:  oh = 3'b010;
      COIN_Q:  oh = 3'b100;
      default: oh = 3'b000;
    endcase
    return oh;
  endfunction

endpackage

// File: rtl/coin_debounce.sv
// One coin-sensor channel: two-flop synchroniser followed by a debounce FSM
// that emits a single-cycle event on each qualified rising level.
module coin_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic event_o
);
  import vm_pkg::*;

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

  logic [1:0]    sync_q;
  logic [1:0]    warm_q;
  chan_state_e   state_q;
  logic [CW-1:0] cnt_q;
  logic          event_q;
  logic          s_x;

  assign s_x     = sync_q[1];
  assign event_o = event_q;

  // warm_q masks the two cleared synchroniser samples after reset, so they
  // never count as real lows and a line held high cannot become a phantom coin.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q  <= 2'b00;
      warm_q  <= 2'b00;
      state_q <= QUAL_LO;
      cnt_q   <= '0;
      event_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only, so every
      // right-hand side reads the value from before this edge.
      sync_q  <= {sync_q[0], raw_i};
      warm_q  <= {warm_q[0], 1'b1};
      event_q <= 1'b0;
      if (warm_q[1]) begin
        unique case (state_q)
          IDLE: begin
            if (s_x) begin
              state_q <= QUAL_HI;
              cnt_q   <= CW'(1);
            end
          end
          QUAL_HI: begin
            if (!s_x) begin
              state_q <= IDLE;
            end else if (cnt_q + CW'(1) == CNT_MAX) begin
              state_q <= HELD;
              event_q <= 1'b1;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
          HELD: begin
            if (!s_x) begin
              state_q <= QUAL_LO;
              cnt_q   <= CW'(1);
            end
          end
          QUAL_LO: begin
            if (s_x) begin
              state_q <= HELD;
            end else if (cnt_q + CW'(1) == CNT_MAX) begin
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q + CW'(1);
            end
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/coin_intake.sv
// Coin front-end: debounces three sensor lines, queues accepted coins and
// presents them one per cycle as registered one-hot pulses.
module coin_intake #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH      = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_n,
  input  logic raw_d,
  input  logic raw_q,
  input  logic coin_en,
  output logic n,
  output logic d,
  output logic q,
  output logic reject,
  output logic full
);
  import vm_pkg::*;

  localparam int unsigned PW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  logic [2:0]    event_w;   // {q, d, n}
  logic [2:0]    pending_q, pending_d;
  logic [2:0]    accept, grant;
  coin_t         push_coin;
  logic          push, pop, reject_d;
  coin_t         fifo_q [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;
  logic [2:0]    out_q;
  logic          reject_q;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_n (
    .clk(clk), .reset(reset), .raw_i(raw_n), .event_o(event_w[0]));
  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_d (
    .clk(clk), .reset(reset), .raw_i(raw_d), .event_o(event_w[1]));
  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_q (
    .clk(clk), .reset(reset), .raw_i(raw_q), .event_o(event_w[2]));

  assign full = (count_q == DEPTH_C);

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned,
    // which would otherwise infer a latch.
    grant     = 3'b000;
    push_coin = COIN_NONE;
    if (pending_q[2]) begin
      grant     = 3'b100;
      push_coin = COIN_Q;
    end else if (pending_q[1]) begin
      grant     = 3'b010;
      push_coin = COIN_D;
    end else if (pending_q[0]) begin
      grant     = 3'b001;
      push_coin = COIN_N;
    end
    pop       = (count_q != '0) && coin_en;
    // A pop on the same edge frees the slot, so a full queue can still accept.
    push      = (grant != 3'b000) && (!full || pop);
    accept    = event_w & ~pending_q & {3{coin_en}};
    reject_d  = ((grant != 3'b000) && !push) || ((event_w & ~accept) != 3'b000);
    pending_d = (pending_q & ~grant) | accept;
  end

  // NOTE: the queue storage has no reset; only the pointers and occupancy
  // define which entries are valid.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= push_coin;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= 3'b000;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      out_q     <= 3'b000;
      reject_q  <= 1'b0;
    end else begin
      pending_q <= pending_d;
      reject_q  <= reject_d;
      out_q     <= pop ? coin_onehot(fifo_q[rd_ptr_q]) : 3'b000;
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: ;
      endcase
    end
  end

  assign n      = out_q[0];
  assign d      = out_q[1];
  assign q      = out_q[2];
  assign reject = reject_q;

endmodule

// File: tb/tb_coin_intake.sv
// Directed bench for coin_intake with a cycle-level behavioural reference
// (qualified-level/run-length debounce, queue of coin codes).
module tb_coin_intake;

  localparam int DEB   = 4;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic raw_n = 1'b0, raw_d = 1'b0, raw_q = 1'b0, coin_en = 1'b0;
  logic n, d, q, reject, full;

  coin_intake #(.DEBOUNCE_CYCLES(DEB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .raw_n(raw_n), .raw_d(raw_d), .raw_q(raw_q),
    .coin_en(coin_en), .n(n), .d(d), .q(q), .reject(reject), .full(full));

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Reference model. Channel index 0=n, 1=d, 2=q; coin code = index + 1.
  bit       live = 1'b0;
  bit [2:0] m_lvl, m_s1, m_s2, m_ev, m_pend;
  int       m_run [3];
  int       m_warm;
  int       m_fifo [$];
  bit [2:0] m_out;
  bit       m_rej;

  always @(posedge clk) begin
    bit [2:0] raw, old_pend, ev_next, out;
    bit       pop, rej;
    int       grant;
    cyc++;
    raw = {raw_q, raw_d, raw_n};
    if (reset) begin
      live   = 1'b1;
      m_lvl  = 3'b111;
      m_s1   = 3'b000;
      m_s2   = 3'b000;
      m_ev   = 3'b000;
      m_pend = 3'b000;
      m_warm = 0;
      m_fifo.delete();
      m_out  = 3'b000;
      m_rej  = 1'b0;
      foreach (m_run[i]) m_run[i] = 0;
    end else if (live) begin
      old_pend = m_pend;
      rej = 1'b0;
      pop = (m_fifo.size() > 0) && coin_en;
      out = pop ? (3'b001 << (m_fifo[0] - 1)) : 3'b000;
      if (pop) void'(m_fifo.pop_front());
      grant = -1;
      for (int i = 2; i >= 0; i--) if (old_pend[i] && grant < 0) grant = i;
      if (grant >= 0) begin
        m_pend[grant] = 1'b0;
        if (m_fifo.size() < DEPTH) m_fifo.push_back(grant + 1);
        else rej = 1'b1;
      end
      for (int i = 0; i < 3; i++) begin
        if (m_ev[i]) begin
          if (!coin_en || old_pend[i]) rej = 1'b1;
          else m_pend[i] = 1'b1;
        end
      end
      ev_next = 3'b000;
      if (m_warm >= 2) begin
        for (int i = 0; i < 3; i++) begin
          if (m_s2[i] != m_lvl[i]) begin
            m_run[i]++;
            if (m_run[i] == DEB) begin
              m_lvl[i]   = m_s2[i];
              m_run[i]   = 0;
              ev_next[i] = m_s2[i];
            end
          end else begin
            m_run[i] = 0;
          end
        end
      end else begin
        m_warm++;
      end
      m_ev  = ev_next;
      m_s2  = m_s1;
      m_s1  = raw;
      m_out = out;
      m_rej = rej;
    end
  end

  // Per-phase pulse bookkeeping for the hand-computed expectations.
  int   cnt [3];
  int   cnt_rej;
  int   first_cyc [3];
  int   seq [$];
  logic full_at_first;

  task automatic clr();
    foreach (cnt[i]) begin
      cnt[i] = 0;
      first_cyc[i] = -1;
    end
    cnt_rej = 0;
    seq.delete();
    full_at_first = 1'bx;
  endtask

  // Single compare process against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (live) begin
      check("n", n, m_out[0]);
      check("d", d, m_out[1]);
      check("q", q, m_out[2]);
      check("reject", reject, m_rej);
      check("full", full, (m_fifo.size() == DEPTH));
      check("onehot", (32'(n) + 32'(d) + 32'(q)) <= 1, 1);
      if (n === 1'b1 || d === 1'b1 || q === 1'b1) begin
        if (seq.size() == 0) full_at_first = full;
      end
      if (n === 1'b1) begin cnt[0]++; seq.push_back(1); if (first_cyc[0] < 0) first_cyc[0] = cyc; end
      if (d === 1'b1) begin cnt[1]++; seq.push_back(2); if (first_cyc[1] < 0) first_cyc[1] = cyc; end
      if (q === 1'b1) begin cnt[2]++; seq.push_back(3); if (first_cyc[2] < 0) first_cyc[2] = cyc; end
      if (reject === 1'b1) cnt_rej++;
    end
  end

  int e;

  initial begin
    clr();
    @(negedge clk);
    coin_en = 1'b1;
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    check("reset_n", n, 0);
    check("reset_reject", reject, 0);
    check("reset_full", full, 0);

    // Single dime: pulse 8 cycles after first high sample.
    tick(6);
    clr();
    raw_d = 1'b1;
    e = cyc + 1;
    tick(10);
    raw_d = 1'b0;
    tick(20);
    check("dime_count", cnt[1], 1);
    check("dime_latency", first_cyc[1], e + 8);
    check("dime_no_n", cnt[0], 0);
    check("dime_no_q", cnt[2], 0);
    check("dime_no_reject", cnt_rej, 0);

    // Three-cycle glitch on nickel.
    clr();
    raw_n = 1'b1;
    tick(3);
    raw_n = 1'b0;
    tick(20);
    check("glitch_no_n", cnt[0], 0);
    check("glitch_no_reject", cnt_rej, 0);

    // All three together: q, d, n on consecutive cycles.
    clr();
    {raw_q, raw_d, raw_n} = 3'b111;
    e = cyc + 1;
    tick(8);
    {raw_q, raw_d, raw_n} = 3'b000;
    tick(20);
    check("triple_q_cycle", first_cyc[2], e + 8);
    check("triple_d_cycle", first_cyc[1], e + 9);
    check("triple_n_cycle", first_cyc[0], e + 10);
    check("triple_pulses", cnt[0] + cnt[1] + cnt[2], 3);

    // Quarter refused while not accepting.
    clr();
    coin_en = 1'b0;
    raw_q = 1'b1;
    tick(8);
    raw_q = 1'b0;
    tick(20);
    check("refused_reject", cnt_rej, 1);
    check("refused_no_q", cnt[2], 0);
    coin_en = 1'b1;
    tick(10);
    check("refused_still_no_q", cnt[2], 0);

    // Fill the queue: accept q,d,n with no pop, then q,d while one pops.
    clr();
    coin_en = 1'b0;
    {raw_q, raw_d, raw_n} = 3'b111;
    tick(6);
    coin_en = 1'b1;
    tick(1);
    coin_en = 1'b0;
    tick(1);
    {raw_q, raw_d, raw_n} = 3'b000;
    tick(10);
    {raw_q, raw_d} = 2'b11;
    tick(6);
    coin_en = 1'b1;
    tick(1);
    coin_en = 1'b0;
    tick(1);
    {raw_q, raw_d} = 2'b00;
    tick(10);
    check("fill_full", full, 1);
    check("fill_one_q_out", cnt[2], 1);
    check("fill_no_reject", cnt_rej, 0);

    // Fifth coin while full and not accepting.
    clr();
    raw_n = 1'b1;
    tick(8);
    raw_n = 1'b0;
    tick(6);
    check("fifth_reject", cnt_rej, 1);
    check("fifth_full", full, 1);
    check("fifth_no_pulse", cnt[0] + cnt[1] + cnt[2], 0);
    coin_en = 1'b1;
    tick(10);
    check("drain_count", seq.size(), 4);
    if (seq.size() == 4) begin
      check("drain_0", seq[0], 2);
      check("drain_1", seq[1], 1);
      check("drain_2", seq[2], 3);
      check("drain_3", seq[3], 2);
    end
    check("drain_full_after_first", full_at_first, 0);
    check("drain_full_end", full, 0);

    // Quarter held through reset: no phantom, then a real coin.
    raw_q = 1'b1;
    tick(2);
    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    clr();
    tick(12);
    check("held_no_phantom", cnt[2], 0);
    raw_q = 1'b0;
    tick(4);
    raw_q = 1'b1;
    tick(4);
    raw_q = 1'b0;
    tick(20);
    check("held_then_coin", cnt[2], 1);
    check("held_no_reject", cnt_rej, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
